// File: rtl/mux2_arbiter_pkg.sv
// Shared constants for the two-requester round-robin burst arbiter:
// FSM state encoding, beat-counter width and a grant-state helper.
package mux2_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    localparam int CNT_W = 32;

    function automatic logic [1:0] gnt_state(input logic idx);
        return idx ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/Mux2to1_64b.sv
// Team 2:1 data mux; 64 bits wide by default, sel=1 picks in1.
module Mux2to1_64b #(
    parameter int WIDTH = 64
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester burst arbiter with round-robin grant and a registered output stage.
// Define MUX2_ARBITER_CNT_EN to add per-requester accepted-beat counters cnt0/cnt1.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src
`ifdef MUX2_ARBITER_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              rr;
    logic              gnt_idx;
    logic              load_ok;
    logic              acc0;
    logic              acc1;
    logic              acc;
    logic              acc_last;
    logic [DATA_W-1:0] sel_data;

    assign gnt_idx = (state == ST_GNT1);

    // The output register can take a beat when empty or being drained this cycle.
    assign load_ok   = !out_valid || out_ready;
    assign in0_ready = !rst && (state == ST_GNT0) && load_ok;
    assign in1_ready = !rst && (state == ST_GNT1) && load_ok;

    assign acc0     = in0_valid && in0_ready;
    assign acc1     = in1_valid && in1_ready;
    assign acc      = acc0 || acc1;
    assign acc_last = gnt_idx ? in1_last : in0_last;

    Mux2to1_64b #(
        .WIDTH (DATA_W)
    ) u_data_mux (
        .sel (gnt_idx),
        .in0 (in0_data),
        .in1 (in1_data),
        .out (sel_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in0_valid && in1_valid) begin
                    state_nxt = gnt_state(rr);
                end else if (in0_valid) begin
                    state_nxt = ST_GNT0;
                end else if (in1_valid) begin
                    state_nxt = ST_GNT1;
                end
            end
            // A grant is only released by an accepted last beat, never by a valid gap.
            ST_GNT0, ST_GNT1: begin
                if (acc && acc_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc && acc_last) begin
                rr <= !gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= acc_last;
            out_src   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX2_ARBITER_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (acc0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (acc1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed vector table, hand sequences and random traffic
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mux2_arbiter;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in0_valid = 1'b0;
    logic [DATA_W-1:0] in0_data = '0;
    logic              in0_last = 1'b0;
    logic              in0_ready;
    logic              in1_valid = 1'b0;
    logic [DATA_W-1:0] in1_data = '0;
    logic              in1_last = 1'b0;
    logic              in1_ready;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_src;
`ifdef MUX2_ARBITER_CNT_EN
    logic [31:0]       cnt0;
    logic [31:0]       cnt1;
`endif

    mux2_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
`ifdef MUX2_ARBITER_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the grant (-1 = nobody), whose turn is next on a tie,
    // what the output register holds, and how many beats each side has delivered.
    int          m_owner;
    bit          m_rr;
    bit          m_ov;
    logic [63:0] m_od;
    bit          m_ol;
    bit          m_os;
    logic [31:0] m_c0;
    logic [31:0] m_c1;

    logic        s_r0, s_r1, s_ov, s_ol, s_os;
    logic [63:0] s_od;
    logic [64:0] outq[$];

    typedef struct {
        bit          rst_b;
        bit          v0, l0, v1, l1, ordy;
        logic [63:0] d0, d1;
        bit          er0, er1, eov;
        logic [63:0] eod;
        bit          elast, esrc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 1'b0;
        m_ov    = 1'b0;
        m_od    = '0;
        m_ol    = 1'b0;
        m_os    = 1'b0;
        m_c0    = '0;
        m_c1    = '0;
    endtask

    // Called at posedge+1; raises rst between edges and checks the async effect.
    task automatic do_reset();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_last  = 1'b0;
        in1_last  = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_readies", {in0_ready, in1_ready}, 0);
`ifdef MUX2_ARBITER_CNT_EN
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cycle(input bit v0, input logic [63:0] d0, input bit l0,
                         input bit v1, input logic [63:0] d1, input bit l1,
                         input bit ordy);
        bit r0, r1, a0, a1, k, alast;
        logic [63:0] adata;
        in0_valid = v0; in0_data = d0; in0_last = l0;
        in1_valid = v1; in1_data = d1; in1_last = l1;
        out_ready = ordy;
        @(negedge clk);
        s_r0 = in0_ready; s_r1 = in1_ready; s_ov = out_valid;
        s_od = out_data;  s_ol = out_last;  s_os = out_src;
        r0 = (m_owner == 0) && (!m_ov || ordy);
        r1 = (m_owner == 1) && (!m_ov || ordy);
        chk("in0_ready", s_r0, r0);
        chk("in1_ready", s_r1, r1);
        chk("out_valid", s_ov, m_ov);
        if (m_ov) begin
            chk("out_data", s_od, m_od);
            chk("out_last", s_ol, m_ol);
            chk("out_src", s_os, m_os);
        end
`ifdef MUX2_ARBITER_CNT_EN
        chk("cnt0", cnt0, m_c0);
        chk("cnt1", cnt1, m_c1);
`endif
        if (s_ov && ordy) outq.push_back({s_os, s_od});
        a0 = v0 && r0;
        a1 = v1 && r1;
        k = a1;
        alast = a1 ? l1 : l0;
        adata = a1 ? d1 : d0;
        if (a0) m_c0 = m_c0 + 1;
        if (a1) m_c1 = m_c1 + 1;
        if (m_owner < 0) begin
            if (v0 && v1) m_owner = int'(m_rr);
            else if (v0) m_owner = 0;
            else if (v1) m_owner = 1;
        end else if ((a0 || a1) && alast) begin
            m_owner = -1;
            m_rr = !k;
        end
        if (a0 || a1) begin
            m_ov = 1'b1; m_od = adata; m_ol = alast; m_os = k;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // In0 3-beat burst, then alternating single-beat bursts from rr=0.
        tbl.push_back('{1, 1,0,0,0,1, 64'hA0, 64'h0,  0,0,0, 64'h0,  0,0});
        tbl.push_back('{0, 1,0,0,0,1, 64'hA0, 64'h0,  1,0,0, 64'h0,  0,0});
        tbl.push_back('{0, 1,0,0,0,1, 64'hA1, 64'h0,  1,0,1, 64'hA0, 0,0});
        tbl.push_back('{0, 1,1,0,0,1, 64'hA2, 64'h0,  1,0,1, 64'hA1, 0,0});
        tbl.push_back('{0, 0,0,0,0,1, 64'h0,  64'h0,  0,0,1, 64'hA2, 1,0});
        tbl.push_back('{0, 0,0,0,0,1, 64'h0,  64'h0,  0,0,0, 64'h0,  0,0});
        tbl.push_back('{1, 1,1,1,1,1, 64'hB0, 64'hC0, 0,0,0, 64'h0,  0,0});
        tbl.push_back('{0, 1,1,1,1,1, 64'hB0, 64'hC0, 1,0,0, 64'h0,  0,0});
        tbl.push_back('{0, 1,1,1,1,1, 64'hB1, 64'hC0, 0,0,1, 64'hB0, 1,0});
        tbl.push_back('{0, 1,1,1,1,1, 64'hB1, 64'hC0, 0,1,0, 64'h0,  0,0});
        tbl.push_back('{0, 1,1,1,1,1, 64'hB1, 64'hC1, 0,0,1, 64'hC0, 1,1});
        tbl.push_back('{0, 1,1,1,1,1, 64'hB1, 64'hC1, 1,0,0, 64'h0,  0,0});
        tbl.push_back('{0, 1,1,1,1,1, 64'hB2, 64'hC1, 0,0,1, 64'hB1, 1,0});
        tbl.push_back('{0, 1,1,1,1,1, 64'hB2, 64'hC1, 0,1,0, 64'h0,  0,0});
        tbl.push_back('{0, 0,0,0,0,1, 64'h0,  64'h0,  0,0,1, 64'hC1, 1,1});

        foreach (tbl[i]) begin
            if (tbl[i].rst_b) do_reset();
            cycle(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].ordy);
            chk($sformatf("tbl%0d_in0_ready", i), s_r0, tbl[i].er0);
            chk($sformatf("tbl%0d_in1_ready", i), s_r1, tbl[i].er1);
            chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].eov);
            if (tbl[i].eov) begin
                chk($sformatf("tbl%0d_out_data", i), s_od, tbl[i].eod);
                chk($sformatf("tbl%0d_out_last", i), s_ol, tbl[i].elast);
                chk($sformatf("tbl%0d_out_src", i), s_os, tbl[i].esrc);
            end
        end

        // In1 burst of 4 must not be preempted by a waiting in0.
        do_reset();
        outq.delete();
        cycle(0, 0, 0, 1, 64'h10, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 64'h20, 1, 1, 64'h10 + i, i == 3, 1);
        cycle(1, 64'h20, 1, 0, 0, 0, 1);
        cycle(1, 64'h20, 1, 0, 0, 0, 1);
        idle_cycles(3);
        chk("burst_outq_size", outq.size(), 5);
        if (outq.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk($sformatf("burst_beat%0d", i), outq[i], {1'b1, 64'h10 + i});
            chk("burst_then_in0", outq[4], {1'b0, 64'h20});
        end

        // Output stall with 0x55 buffered, then release with a same-cycle reload.
        do_reset();
        cycle(1, 64'h55, 0, 0, 0, 0, 1);
        cycle(1, 64'h55, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 64'h56, 0, 0, 0, 0, 0);
            chk($sformatf("stall%0d_data", i), s_od, 64'h55);
            chk($sformatf("stall%0d_in0_ready", i), s_r0, 0);
        end
        cycle(1, 64'h56, 0, 0, 0, 0, 1);
        chk("release_in0_ready", s_r0, 1);
        cycle(1, 64'h57, 1, 0, 0, 0, 1);
        chk("release_next_valid", s_ov, 1);
        chk("release_next_data", s_od, 64'h56);
        idle_cycles(3);

        // Reset mid-burst, then in1 is granted from a clean IDLE.
        cycle(1, 64'h60, 0, 0, 0, 0, 1);
        cycle(1, 64'h60, 0, 0, 0, 0, 1);
        cycle(1, 64'h61, 0, 0, 0, 0, 1);
        chk("pre_rst_out_valid", s_ov, 1);
        do_reset();
        cycle(0, 0, 0, 1, 64'h70, 1, 1);
        chk("post_rst_idle_in1_ready", s_r1, 0);
        cycle(0, 0, 0, 1, 64'h70, 1, 1);
        chk("post_rst_in1_granted", s_r1, 1);
        idle_cycles(2);

`ifdef MUX2_ARBITER_CNT_EN
        do_reset();
        cycle(1, 64'h1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cycle(1, 64'h1, i == 6, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 64'h2, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 64'h2, i == 2, 1);
        idle_cycles(2);
        chk("cnt0_seven", cnt0, 7);
        chk("cnt1_three", cnt1, 3);
        force dut.cnt0 = 32'hFFFF_FFFF;
        #1;
        release dut.cnt0;
        m_c0 = 32'hFFFF_FFFF;
        cycle(1, 64'h3, 1, 0, 0, 0, 1);
        cycle(1, 64'h3, 1, 0, 0, 0, 1);
        idle_cycles(2);
        chk("cnt0_wrap", cnt0, 0);
`endif

        // Random traffic with occasional stalls and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of every data path.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have ports in0_valid/in1_valid, input, 1 each: requester k offers a beat.
REQ-005 SHALL have ports in0_data/in1_data, input, DATA_W each: requester k beat data.
REQ-006 SHALL have ports in0_last/in1_last, input, 1 each: beat ends requester k burst.
REQ-007 SHALL have ports in0_ready/in1_ready, output, 1 each: beat from requester k accepted this cycle.
REQ-008 SHALL have port out_valid, output, 1: output register holds a beat.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the beat this cycle.
REQ-010 SHALL have ports out_data (DATA_W), out_last (1) and out_src (1), outputs: registered beat, last flag, source index.

Function
REQ-011 SHALL implement states IDLE, GNT0, GNT1 and a 1-bit round-robin pointer rr.
REQ-012 In IDLE, SHALL assert no inN_ready.
REQ-013 In IDLE, SHALL go to GNTk if only ink_valid is high.
REQ-014 In IDLE with both valids high, SHALL go to GNT(rr); with neither high, SHALL stay in IDLE.
REQ-015 In GNTk, inK_ready SHALL equal (!out_valid || out_ready); the other ready SHALL be 0.
REQ-016 An accepted beat (inK_valid && inK_ready) SHALL load out_data/out_last from requester k, out_src=k, out_valid=1 at the next edge.
REQ-017 An accepted beat with inK_last=1 SHALL return the FSM to IDLE and set rr to !k.
REQ-018 Grant SHALL be held across non-last beats, including cycles with inK_valid=0: no preemption mid-burst.
REQ-019 Latency SHALL be: request seen in IDLE at cycle t -> granted at t+1 -> out_valid at t+2 with out_ready high throughout; one beat per cycle thereafter.
REQ-020 out_valid SHALL clear after out_ready handshake when no new beat is loaded.
REQ-021 While out_valid && !out_ready, out_data/out_last/out_src SHALL hold stable and inN_ready SHALL be 0.
REQ-022 Output-register handshake and a new accept in the same cycle SHALL reload the register without a bubble.

Reset
REQ-023 rst SHALL asynchronously force IDLE, rr=0, out_valid=0, out_data=0, out_last=0, out_src=0, all counters 0.
REQ-024 Reset mid-burst SHALL drop the burst and the buffered beat; no partial state SHALL survive.
REQ-025 inN_ready SHALL be 0 while rst is high.

Configuration
REQ-026 Macro MUX2_ARBITER_CNT_EN, when defined, SHALL add outputs cnt0 and cnt1 (32 bits each) counting accepted beats per requester, wrapping at 2^32-1 -> 0.
REQ-027 Without MUX2_ARBITER_CNT_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and the counter width constant 32.
REQ-029 Data selection SHALL instantiate the team's existing 2:1 64-bit mux (Mux2to1_64b), with select driven by the granted index; no other sub-module.

Verification
REQ-030 Reset, then in0 sends 3 beats 0xA0..0xA2 (last on the third) with out_ready=1 -> outputs 0xA0, 0xA1, 0xA2 on consecutive cycles starting at t+2, out_src=0, FSM back in IDLE.
REQ-031 Both valid from IDLE with rr=0, single-beat bursts repeated -> grants alternate 0,1,0,1 and out_src sequence is 0,1,0,1.
REQ-032 in1 burst of 4 with in0_valid asserted throughout -> all 4 in1 beats are output before any in0 beat.
REQ-033 out_ready=0 for 5 cycles with a beat 0x55 buffered -> out_data stays 0x55, in0_ready stays 0; release gives one transfer, then the next beat.
REQ-034 rst pulsed mid-burst -> out_valid is 0 immediately, with no edge needed; after release, an in1 request is granted from IDLE with rr=0.
REQ-035 With MUX2_ARBITER_CNT_EN defined, 7 in0 beats and 3 in1 beats -> cnt0=7, cnt1=3; counter preset to 0xFFFFFFFF plus one beat -> 0.
